// File: rtl/baccarat_datapath.sv
`default_nettype none
// ============================================================================
// Module   : baccarat_datapath
// Purpose  : Holds the player and dealer hands for the baccarat game state
//            machine and scores each hand combinationally from its card
//            registers. Also tracks slot occupancy and raises sticky flags
//            for load-protocol violations and illegal rank codes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   slow_clock            in   game clock, rising-edge active
//   resetb                in   asynchronous active-low reset
//   new_card[3:0]         in   rank code from dealer, sampled on a load edge
//   load_pcard1..3        in   player slot load strobes
//   load_dcard1..3        in   dealer slot load strobes
//   pcard1..3[3:0]        out  player card registers (raw rank, 0 = empty)
//   dcard1..3[3:0]        out  dealer card registers (raw rank, 0 = empty)
//   pscore[3:0]           out  player hand score 0..9
//   dscore[3:0]           out  dealer hand score 0..9
//   pcard_count[1:0]      out  player slots filled 0..3
//   dcard_count[1:0]      out  dealer slots filled 0..3
//   proto_err             out  sticky load-protocol violation
//   bad_card              out  sticky illegal rank code seen on a load
// ============================================================================
module baccarat_datapath #(
  parameter int RANK_MAX = 13,
  parameter int MODULUS  = 10
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] new_card,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [1:0] pcard_count,
  output logic [1:0] dcard_count,
  output logic       proto_err,
  output logic       bad_card
);

  localparam logic [3:0] C_RANK_MAX = 4'(RANK_MAX);
  localparam logic [4:0] C_MOD1     = 5'(MODULUS);
  localparam logic [4:0] C_MOD2     = 5'(2 * MODULUS);

  // Baccarat point value: pips count face value, tens and court cards count
  // zero, and anything outside the legal rank range also counts zero.
  function automatic logic [3:0] card_val(input logic [3:0] c);
    if ((c >= 4'd1) && (c <= 4'd9) && (c <= C_RANK_MAX)) begin
      return c;
    end
    return 4'd0;
  endfunction

  // Sum of three cards is at most 27, so two conditional subtractions are
  // enough to reduce it modulo MODULUS without a divider.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    logic [4:0] red;
    sum = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    if (sum >= C_MOD2) begin
      red = sum - C_MOD2;
    end else if (sum >= C_MOD1) begin
      red = sum - C_MOD1;
    end else begin
      red = sum;
    end
    return red[3:0];
  endfunction

  // Adds the per-edge increment to a hand counter, clamping at three.
  function automatic logic [1:0] sat_add(input logic [1:0] cnt,
                                         input logic [1:0] inc);
    logic [2:0] s;
    s = {1'b0, cnt} + {1'b0, inc};
    return (s > 3'd3) ? 2'd3 : s[1:0];
  endfunction

  logic [5:0] w_load;      // {d3,d2,d1,p3,p2,p1}
  logic [5:0] w_empty;     // slot register is zero before this edge
  logic       w_legal;     // new_card is a legal rank
  logic       w_multi;     // more than one strobe this cycle
  logic       w_overwrite; // load into an occupied slot
  logic       w_order;     // slot loaded before its predecessor
  logic [1:0] w_p_inc;
  logic [1:0] w_d_inc;

  assign w_load  = {load_dcard3, load_dcard2, load_dcard1,
                    load_pcard3, load_pcard2, load_pcard1};
  assign w_empty = {dcard3 == 4'd0, dcard2 == 4'd0, dcard1 == 4'd0,
                    pcard3 == 4'd0, pcard2 == 4'd0, pcard1 == 4'd0};
  assign w_legal = (new_card != 4'd0) && (new_card <= C_RANK_MAX);

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign w_multi     = (w_load & (w_load - 6'd1)) != 6'd0;
  assign w_overwrite = (w_load & ~w_empty) != 6'd0;
  assign w_order     = (load_pcard2 && w_empty[0]) || (load_pcard3 && w_empty[1]) ||
                       (load_dcard2 && w_empty[3]) || (load_dcard3 && w_empty[4]);

  // Illegal codes are still stored but never count as filling a slot.
  always_comb begin
    w_p_inc = 2'd0;
    w_d_inc = 2'd0;
    if (w_legal) begin
      w_p_inc = {1'b0, w_load[0] & w_empty[0]} + {1'b0, w_load[1] & w_empty[1]} +
                {1'b0, w_load[2] & w_empty[2]};
      w_d_inc = {1'b0, w_load[3] & w_empty[3]} + {1'b0, w_load[4] & w_empty[4]} +
                {1'b0, w_load[5] & w_empty[5]};
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pcard1      <= 4'd0;
      pcard2      <= 4'd0;
      pcard3      <= 4'd0;
      dcard1      <= 4'd0;
      dcard2      <= 4'd0;
      dcard3      <= 4'd0;
      pcard_count <= 2'd0;
      dcard_count <= 2'd0;
      proto_err   <= 1'b0;
      bad_card    <= 1'b0;
    end else begin
      if (load_pcard1) pcard1 <= new_card;
      if (load_pcard2) pcard2 <= new_card;
      if (load_pcard3) pcard3 <= new_card;
      if (load_dcard1) dcard1 <= new_card;
      if (load_dcard2) dcard2 <= new_card;
      if (load_dcard3) dcard3 <= new_card;
      pcard_count <= sat_add(pcard_count, w_p_inc);
      dcard_count <= sat_add(dcard_count, w_d_inc);
      if (w_multi || w_overwrite || w_order) proto_err <= 1'b1;
      if ((w_load != 6'd0) && !w_legal)      bad_card  <= 1'b1;
    end
  end

  // Scores follow the registers directly so a freshly loaded card is
  // reflected in the same cycle it becomes visible.
  assign pscore = hand_score(pcard1, pcard2, pcard3);
  assign dscore = hand_score(dcard1, dcard2, dcard3);

endmodule
`default_nettype wire
